// File: rtl/mesh_port_arbiter.sv
`default_nettype none
// ============================================================================
// mesh_port_arbiter : round-robin feeder from N_REQ source FIFOs into one mesh input port
// Revision 1.0
// ============================================================================
module mesh_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int pckg_sz   = 41,
  parameter int BUF_DEPTH = 4,
  parameter int STALL_LIM = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           pndng_req,
  input  logic [N_REQ*pckg_sz-1:0]   data_req,
  output logic [N_REQ-1:0]           pop_req,
  output logic [pckg_sz-1:0]         data_out_i_in,
  output logic                       pndng_i_in,
  input  logic                       popin,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [15:0]                pkt_cnt,
  output logic                       stall
);

  localparam int c_IDW = $clog2(N_REQ);
  localparam int c_PW  = $clog2(BUF_DEPTH);
  localparam int c_CW  = $clog2(BUF_DEPTH + 1);

  logic [pckg_sz-1:0] r_mem [BUF_DEPTH];
  logic [c_PW-1:0]    r_head;
  logic [c_PW-1:0]    r_tail;
  logic [c_CW-1:0]    r_cnt;
  logic [pckg_sz-1:0] r_last;
  logic [c_IDW-1:0]   r_rr;
  logic [c_IDW-1:0]   r_gid;
  logic [15:0]        r_pkt;
  logic [15:0]        r_sc;
  logic               r_stall;

  logic               w_acc;
  logic               w_space;
  logic               w_gnt_vld;
  logic [c_IDW-1:0]   w_gnt;
  logic [pckg_sz-1:0] w_gnt_data;
  logic [15:0]        w_sc_nxt;

  assign w_acc      = popin && (r_cnt != '0);
  assign w_space    = (r_cnt < c_CW'(BUF_DEPTH)) || w_acc;
  assign pndng_i_in = (r_cnt != '0);
  // Once drained, the port keeps showing the last packet that sat at the head.
  assign data_out_i_in = (r_cnt != '0) ? r_mem[r_head] : r_last;

  always_comb begin
    int               idx;
    logic [c_IDW-1:0] sel;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_rr) + k) % N_REQ;
      sel = c_IDW'(idx);
      if (!w_gnt_vld && pndng_req[sel]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = sel;
      end
    end
    if (!(w_space && reset)) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign pop_req    = w_gnt_vld ? (N_REQ'(1) << w_gnt) : '0;
  assign w_gnt_data = data_req[int'(w_gnt)*pckg_sz +: pckg_sz];

  always_comb begin
    w_sc_nxt = r_sc;
    if (w_acc) begin
      w_sc_nxt = '0;
    end else if (pndng_i_in && !popin && (r_sc < 16'(STALL_LIM))) begin
      w_sc_nxt = r_sc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_rr    <= c_IDW'(N_REQ - 1);
      r_gid   <= '0;
      r_pkt   <= '0;
      r_sc    <= '0;
      r_stall <= 1'b0;
    end else begin
      if (r_cnt != '0) begin
        r_last <= r_mem[r_head];
      end
      if (w_gnt_vld) begin
        r_mem[r_tail] <= w_gnt_data;
        r_tail        <= (r_tail == c_PW'(BUF_DEPTH - 1)) ? '0 : r_tail + 1'b1;
        r_rr          <= w_gnt;
        r_gid         <= w_gnt;
      end
      if (w_acc) begin
        r_head <= (r_head == c_PW'(BUF_DEPTH - 1)) ? '0 : r_head + 1'b1;
        r_pkt  <= r_pkt + 16'd1;
      end
      if (w_gnt_vld && !w_acc) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_gnt_vld && w_acc) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_sc <= w_sc_nxt;
      if (w_sc_nxt == 16'(STALL_LIM)) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign grant_id = r_gid;
  assign pkt_cnt  = r_pkt;
  assign stall    = r_stall;

endmodule
`default_nettype wire
